// File: rtl/clk_ratio_pkg.sv
// Shared FSM encoding and default sizing for the clock-ratio detector.
package clk_ratio_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2,
    LOCKED    = 2'd3
  } state_t;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_LOCK_CNT    = 3;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_ratio_detect_sync_edge_det.sv
// Synchronizes the measured clock into i_ref_clk and emits registered
// one-cycle rise/fall pulses from the last two flops of the chain.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_ref_clk,
  input  logic i_rst_n,
  input  logic i_meas_clk,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic [SYNC_STAGES:0]   primed_reg;
  logic                   rise_reg;
  logic                   fall_reg;
  logic                   sync_last;
  logic                   primed;

  assign sync_last = sync_reg[SYNC_STAGES-1];
  // The reset value of the chain is not a real sample; only compare once the
  // history flop holds a genuinely sampled level, so a clock that is high at
  // reset release is not mistaken for a rise.
  assign primed    = primed_reg[SYNC_STAGES];

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_reg   <= '0;
      hist_reg   <= 1'b0;
      primed_reg <= '0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], i_meas_clk};
      hist_reg   <= sync_last;
      primed_reg <= {primed_reg[SYNC_STAGES-1:0], 1'b1};
      rise_reg   <= primed & sync_last & ~hist_reg;
      fall_reg   <= primed & ~sync_last & hist_reg;
    end
  end

  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;

endmodule

// File: rtl/clk_ratio_detect.sv
// Measures high/low phase lengths of a divided clock in i_ref_clk cycles,
// reports the ratio each period and tracks lock / sticky error.
module clk_ratio_detect
  import clk_ratio_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_meas_clk,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W-1:0] o_low_cnt,
  output logic [CNT_W:0]   o_ratio,
  output logic             o_odd,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_err
);

  localparam int                 MATCH_W   = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_CNT);

  logic rise_pulse;
  logic fall_pulse;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .i_ref_clk (i_ref_clk),
    .i_rst_n   (i_rst_n),
    .i_meas_clk(i_meas_clk),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  state_t             state_reg,  state_next;
  logic [CNT_W-1:0]   cnt_reg,    cnt_next;
  logic [CNT_W-1:0]   hold_reg,   hold_next;
  logic [CNT_W-1:0]   high_reg,   high_next;
  logic [CNT_W-1:0]   low_reg,    low_next;
  logic [CNT_W:0]     ratio_reg,  ratio_next;
  logic               odd_reg,    odd_next;
  logic               valid_reg,  valid_next;
  logic               locked_reg, locked_next;
  logic               err_reg,    err_next;
  logic [MATCH_W-1:0] match_reg,  match_next;

  logic               any_edge;
  logic               cnt_sat;
  logic               timeout;
  logic [CNT_W:0]     ratio_new;
  logic [MATCH_W-1:0] match_inc;

  assign any_edge  = rise_pulse | fall_pulse;
  assign cnt_sat   = (cnt_reg == CNT_MAX);
  // An edge arriving together with saturation wins: the saturated count is captured.
  assign timeout   = cnt_sat & ~any_edge;
  assign ratio_new = {1'b0, hold_reg} + {1'b0, cnt_reg};
  assign match_inc = (match_reg == MATCH_MAX) ? match_reg : match_reg + 1'b1;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hold_next   = hold_reg;
    high_next   = high_reg;
    low_next    = low_reg;
    ratio_next  = ratio_reg;
    odd_next    = odd_reg;
    valid_next  = 1'b0;
    locked_next = locked_reg;
    err_next    = err_reg;
    match_next  = match_reg;

    if (!i_enable) begin
      state_next  = IDLE;
      cnt_next    = '0;
      hold_next   = '0;
      high_next   = '0;
      low_next    = '0;
      ratio_next  = '0;
      odd_next    = 1'b0;
      locked_next = 1'b0;
      err_next    = 1'b0;
      match_next  = '0;
    end else begin
      if (state_reg == IDLE) begin
        cnt_next = '0;
      end else if (any_edge) begin
        cnt_next = CNT_W'(1);
      end else if (!cnt_sat) begin
        cnt_next = cnt_reg + 1'b1;
      end

      case (state_reg)
        IDLE: state_next = WAIT_RISE;

        WAIT_RISE: begin
          if (rise_pulse) begin
            state_next = MEASURE;
          end else if (timeout) begin
            err_next    = 1'b1;
            locked_next = 1'b0;
            match_next  = '0;
          end
        end

        MEASURE, LOCKED: begin
          if (fall_pulse) begin
            hold_next = cnt_reg;
          end
          if (rise_pulse) begin
            low_next   = cnt_reg;
            high_next  = hold_reg;
            ratio_next = ratio_new;
            odd_next   = (hold_reg != cnt_reg);
            valid_next = 1'b1;
            if (ratio_new == ratio_reg) begin
              match_next = match_inc;
              if ((state_reg == MEASURE) && (match_inc == MATCH_MAX)) begin
                state_next  = LOCKED;
                locked_next = 1'b1;
              end
            end else begin
              match_next = '0;
              if (state_reg == LOCKED) begin
                state_next  = MEASURE;
                locked_next = 1'b0;
                err_next    = 1'b1;
              end
            end
          end else if (timeout) begin
            state_next  = WAIT_RISE;
            locked_next = 1'b0;
            err_next    = 1'b1;
            match_next  = '0;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      hold_reg   <= '0;
      high_reg   <= '0;
      low_reg    <= '0;
      ratio_reg  <= '0;
      odd_reg    <= 1'b0;
      valid_reg  <= 1'b0;
      locked_reg <= 1'b0;
      err_reg    <= 1'b0;
      match_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hold_reg   <= hold_next;
      high_reg   <= high_next;
      low_reg    <= low_next;
      ratio_reg  <= ratio_next;
      odd_reg    <= odd_next;
      valid_reg  <= valid_next;
      locked_reg <= locked_next;
      err_reg    <= err_next;
      match_reg  <= match_next;
    end
  end

  assign o_high_cnt = high_reg;
  assign o_low_cnt  = low_reg;
  assign o_ratio    = ratio_reg;
  assign o_odd      = odd_reg;
  assign o_valid    = valid_reg;
  assign o_locked   = locked_reg;
  assign o_err      = err_reg;

endmodule

// File: tb/tb_clk_ratio_detect.sv
// Scoreboard bench: a default instance and a CNT_W=4 instance share stimulus;
// expected periods are queued when the measured clock completes a period.
module tb_clk_ratio_detect;
  import clk_ratio_pkg::*;

  localparam int LOCK = 3;
  localparam int SYNC = 2;

  typedef struct {
    int high; int low; int ratio; int odd; int locked; int err; int vcyc;
  } exp_t;
  typedef struct { int h; int l; } per_t;

  logic i_ref_clk  = 1'b0;
  logic i_rst_n    = 1'b1;
  logic i_enable   = 1'b0;
  logic i_meas_clk = 1'b0;

  logic [7:0] m_high, m_low;
  logic [8:0] m_ratio;
  logic       m_odd, m_valid, m_locked, m_err;
  logic [3:0] w_high, w_low;
  logic [4:0] w_ratio;
  logic       w_odd, w_valid, w_locked, w_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   main_valids = 0;
  exp_t q_main[$];
  exp_t q_w4[$];
  per_t gen_q[$];
  int   mdl_prev, mdl_match;
  bit   mdl_locked, mdl_err, armed;

  clk_ratio_detect dut (
    .i_ref_clk(i_ref_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_meas_clk(i_meas_clk),
    .o_high_cnt(m_high), .o_low_cnt(m_low), .o_ratio(m_ratio), .o_odd(m_odd),
    .o_valid(m_valid), .o_locked(m_locked), .o_err(m_err)
  );

  clk_ratio_detect #(.CNT_W(4)) dut_w4 (
    .i_ref_clk(i_ref_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_meas_clk(i_meas_clk),
    .o_high_cnt(w_high), .o_low_cnt(w_low), .o_ratio(w_ratio), .o_odd(w_odd),
    .o_valid(w_valid), .o_locked(w_locked), .o_err(w_err)
  );

  always #5 i_ref_clk = ~i_ref_clk;
  always @(posedge i_ref_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference behaviour of one completed period: match counting, lock, sticky error.
  task automatic push_period(input int h, input int l);
    exp_t e;
    int   r;
    r = h + l;
    if (r == mdl_prev) mdl_match = (mdl_match == LOCK) ? LOCK : mdl_match + 1;
    else               mdl_match = 0;
    if (mdl_locked && (r != mdl_prev)) begin
      mdl_err = 1'b1; mdl_locked = 1'b0; mdl_match = 0;
    end else if (!mdl_locked && (mdl_match == LOCK)) begin
      mdl_locked = 1'b1;
    end
    mdl_prev = r;
    e.high = h; e.low = l; e.ratio = r; e.odd = (h != l) ? 1 : 0;
    e.locked = mdl_locked ? 1 : 0; e.err = mdl_err ? 1 : 0;
    e.vcyc = cyc + SYNC + 2;
    q_main.push_back(e);
    q_w4.push_back(e);
  endtask

  task automatic model_reset();
    mdl_prev = 0; mdl_match = 0; mdl_locked = 1'b0; mdl_err = 1'b0; armed = 1'b0;
    q_main.delete(); q_w4.delete(); main_valids = 0;
  endtask

  task automatic add_periods(input int n, input int h, input int l);
    per_t p;
    p.h = h; p.l = l;
    repeat (n) gen_q.push_back(p);
  endtask

  // Plays the period table; the rise that closes a period queues its expectation.
  task automatic drive_periods();
    per_t p;
    int   ph, pl;
    ph = 0; pl = 0;
    @(posedge i_ref_clk);
    while (gen_q.size() > 0) begin
      p = gen_q.pop_front();
      #2 i_meas_clk = 1'b1;
      if (armed) push_period(ph, pl);
      armed = 1'b1;
      repeat (p.h) @(posedge i_ref_clk);
      #2 i_meas_clk = 1'b0;
      repeat (p.l) @(posedge i_ref_clk);
      ph = p.h; pl = p.l;
    end
  endtask

  task automatic settle(input string tag);
    repeat (8) @(posedge i_ref_clk);
    #2;
    check_eq({tag, "_main_drain"}, q_main.size(), 0);
    check_eq({tag, "_w4_drain"}, q_w4.size(), 0);
    check_eq({tag, "_main_locked"}, 32'(m_locked), 32'(mdl_locked));
  endtask

  task automatic en_pulse(input string tag);
    @(posedge i_ref_clk);
    #2 i_enable = 1'b0;
    @(posedge i_ref_clk);
    #2;
    check_eq({tag, "_clr_ratio"}, 32'(m_ratio), 0);
    check_eq({tag, "_clr_locked"}, 32'(m_locked), 0);
    check_eq({tag, "_clr_err"}, 32'(m_err), 0);
    check_eq({tag, "_clr_w4_err"}, 32'(w_err), 0);
    check_eq({tag, "_clr_w4_state"}, 32'(dut_w4.state_reg), 32'(IDLE));
    i_enable = 1'b1;
    model_reset();
  endtask

  always @(negedge i_ref_clk) begin
    exp_t e;
    if (i_rst_n && m_valid) begin
      main_valids++;
      $display("txn main: cycle=%0d high=%0d low=%0d ratio=%0d odd=%0d locked=%0d err=%0d",
               cyc, m_high, m_low, m_ratio, m_odd, m_locked, m_err);
      if (q_main.size() == 0) begin
        check_eq("main_unexpected_valid", 32'(m_valid), 0);
      end else begin
        e = q_main.pop_front();
        check_eq("main_high", 32'(m_high), e.high);
        check_eq("main_low", 32'(m_low), e.low);
        check_eq("main_ratio", 32'(m_ratio), e.ratio);
        check_eq("main_odd", 32'(m_odd), e.odd);
        check_eq("main_locked", 32'(m_locked), e.locked);
        check_eq("main_err", 32'(m_err), e.err);
        check_eq("main_latency", cyc, e.vcyc);
      end
    end
  end

  always @(negedge i_ref_clk) begin
    exp_t e;
    if (i_rst_n && w_valid) begin
      if (q_w4.size() == 0) begin
        check_eq("w4_unexpected_valid", 32'(w_valid), 0);
      end else begin
        e = q_w4.pop_front();
        check_eq("w4_high", 32'(w_high), e.high);
        check_eq("w4_low", 32'(w_low), e.low);
        check_eq("w4_ratio", 32'(w_ratio), e.ratio);
        check_eq("w4_locked", 32'(w_locked), e.locked);
        check_eq("w4_err", 32'(w_err), e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got cycle %0d expected finish before time limit", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    #1 i_rst_n = 1'b0;
    #1;
    check_eq("rst_ratio", 32'(m_ratio), 0);
    check_eq("rst_high", 32'(m_high), 0);
    check_eq("rst_valid", 32'(m_valid), 0);
    check_eq("rst_locked", 32'(m_locked), 0);
    check_eq("rst_err", 32'(m_err), 0);
    check_eq("rst_state", 32'(dut.state_reg), 32'(IDLE));
    #21 i_rst_n = 1'b1;
    @(posedge i_ref_clk);
    #2 i_enable = 1'b1;
    model_reset();
    repeat (3) @(posedge i_ref_clk);

    add_periods(6, 2, 2);
    drive_periods();
    settle("div4");
    en_pulse("div4");

    add_periods(6, 2, 3);
    drive_periods();
    settle("div5");
    check_eq("div5_err", 32'(m_err), 0);
    en_pulse("div5");

    add_periods(5, 3, 3);
    add_periods(5, 4, 4);
    drive_periods();
    settle("chg");
    check_eq("chg_err_sticky", 32'(m_err), 32'(mdl_err));
    en_pulse("chg");

    add_periods(3, 15, 3);
    drive_periods();
    settle("sat");
    check_eq("sat_w4_no_err", 32'(w_err), 0);

    model_reset();
    add_periods(6, 3, 3);
    fork
      drive_periods();
      begin
        @(posedge i_meas_clk);
        @(posedge i_ref_clk);
        #3 i_rst_n = 1'b0;
        #1;
        check_eq("rstmid_ratio", 32'(m_ratio), 0);
        check_eq("rstmid_high", 32'(m_high), 0);
        check_eq("rstmid_low", 32'(m_low), 0);
        check_eq("rstmid_w4_ratio", 32'(w_ratio), 0);
        model_reset();
        @(posedge i_ref_clk);
        #3 i_rst_n = 1'b1;
      end
    join
    settle("rstmid");
    check_eq("rstmid_valid_count", main_valids, 4);
    en_pulse("rstmid");

    add_periods(5, 2, 2);
    drive_periods();
    settle("tmo");
    repeat (12) @(posedge i_ref_clk);
    #2;
    check_eq("tmo_w4_err", 32'(w_err), 1);
    check_eq("tmo_w4_locked", 32'(w_locked), 0);
    check_eq("tmo_w4_state", 32'(dut_w4.state_reg), 32'(WAIT_RISE));
    check_eq("tmo_w4_ratio_hold", 32'(w_ratio), 4);
    check_eq("tmo_w4_high_hold", 32'(w_high), 2);
    check_eq("tmo_main_err", 32'(m_err), 0);
    check_eq("tmo_main_locked", 32'(m_locked), 1);
    en_pulse("tmo");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_ratio_detect.md
CLK_RATIO_DETECT -- requirements
Module: clk_ratio_detect

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of each phase counter.
REQ-002 The block SHALL have parameter LOCK_CNT, default 3, giving the number of consecutive matching periods required for lock.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for i_meas_clk (minimum 2).
REQ-004 The block SHALL have port i_ref_clk  in  1  measurement clock; all state is clocked on its rising edge.
REQ-005 The block SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port i_enable  in  1  measurement enable; low synchronously clears all state.
REQ-007 The block SHALL have port i_meas_clk  in  1  divided clock under test, asynchronous to i_ref_clk.
REQ-008 The block SHALL have port o_high_cnt  out  CNT_W  i_ref_clk cycles in the last complete high phase.
REQ-009 The block SHALL have port o_low_cnt  out  CNT_W  i_ref_clk cycles in the last complete low phase.
REQ-010 The block SHALL have port o_ratio  out  CNT_W+1  o_high_cnt + o_low_cnt of the last complete period.
REQ-011 The block SHALL have port o_odd  out  1  set when o_high_cnt != o_low_cnt.
REQ-012 The block SHALL have port o_valid  out  1  single-cycle pulse when a period completes.
REQ-013 The block SHALL have port o_locked  out  1  stable ratio detected.
REQ-014 The block SHALL have port o_err  out  1  sticky error: timeout, or ratio change while locked.

Function
REQ-015 i_meas_clk SHALL pass through a SYNC_STAGES flop chain followed by one history flop; a rise or fall is detected from the last two flops.
REQ-016 The phase counter SHALL load 1 on a detected edge, increment on every other cycle, and saturate at 2^CNT_W-1.
REQ-017 The FSM states SHALL be IDLE, WAIT_RISE, MEASURE, LOCKED; IDLE->WAIT_RISE when i_enable=1.
REQ-018 In WAIT_RISE, the first detected rise SHALL move the FSM to MEASURE; no partial phase is reported.
REQ-019 In MEASURE/LOCKED, a detected fall SHALL capture the counter into a high-phase holding register.
REQ-020 In MEASURE/LOCKED, a detected rise SHALL capture the counter into o_low_cnt, copy the holding register to o_high_cnt, update o_ratio/o_odd, and pulse o_valid, all on the same edge.
REQ-021 Latency: outputs SHALL update on the (SYNC_STAGES+1)th i_ref_clk edge after the edge that first samples the i_meas_clk transition.
REQ-022 The match counter SHALL increment when the new o_ratio equals the previous o_ratio, clear otherwise, and saturate at LOCK_CNT.
REQ-023 MEASURE->LOCKED SHALL occur, with o_locked set, on the o_valid cycle where the match counter reaches LOCK_CNT.
REQ-024 In LOCKED, a ratio mismatch SHALL set o_err, clear o_locked and the match counter, and return to MEASURE.
REQ-025 In MEASURE, a mismatch SHALL only clear the match counter; o_err is unaffected.
REQ-026 Timeout: counter at saturation with no edge in the same cycle SHALL set o_err, clear o_locked, and move to WAIT_RISE; o_high_cnt/o_low_cnt/o_ratio hold.
REQ-027 If an edge and saturation coincide, the edge SHALL win and the saturated value SHALL be captured.
REQ-028 o_err SHALL stay set until i_enable=0 or reset.
REQ-029 i_enable=0 SHALL return all outputs and the FSM (IDLE) to their reset values on the next edge; the synchronizer keeps running.

Reset
REQ-030 On i_rst_n=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the counters and synchronizer flops SHALL be 0, asynchronously.
REQ-031 Reset deassertion mid-period SHALL restart acquisition via WAIT_RISE; no stale period is reported.

Structure
REQ-032 Package clk_ratio_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-033 The synchronizer plus edge detector SHALL be the sub-module sync_edge_det, with outputs rise_pulse and fall_pulse.

Verification
REQ-034 Divide-by-4 clock derived from i_ref_clk -> o_high_cnt=2, o_low_cnt=2, o_ratio=4, o_odd=0; o_locked is set on the 4th o_valid.
REQ-035 Divide-by-5 (high 2/low 3) -> o_ratio=5, o_odd=1, o_locked set; o_err=0.
REQ-036 Once locked at ratio 6, switch to ratio 8 -> o_err=1 and o_locked=0 on the first ratio-8 o_valid; relock after 3 further matching periods.
REQ-037 With CNT_W=4, hold i_meas_clk low for 20 cycles -> o_err=1 and FSM in WAIT_RISE; pulse i_enable low -> o_err=0.
REQ-038 Assert i_rst_n mid high-phase, then release -> all outputs 0; first o_valid comes only after a full rise-to-rise period.
